// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared state type, S-memory owner codes and printable-byte test for the key search
package arc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEN_REQ,
      ST_LEN_GET,
      ST_INIT_GO,
      ST_INIT_WAIT,
      ST_KSA_GO,
      ST_KSA_WAIT,
      ST_PRGA_GO,
      ST_PRGA_WAIT,
      ST_SCAN_REQ,
      ST_SCAN_GET,
      ST_NEXT,
      ST_DONE
   } crack_state_t;

   localparam logic [1:0] S_SEL_INIT = 2'd0;
   localparam logic [1:0] S_SEL_KSA  = 2'd1;
   localparam logic [1:0] S_SEL_PRGA = 2'd2;

   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

endpackage

// File: rtl/arc4_crack_ctrl.sv
// rtl/arc4_crack_ctrl.sv - ARC4 key-search sequencer (init -> ksa -> prga -> printable check per key)
// Build option CRACK_SNOOP_CHECK_EN: judge plaintext from the prga write snoop instead of a pt read-back scan.
module arc4_crack_ctrl
   import arc4_pkg::*;
#(
   parameter logic [23:0] KEY_FIRST = 24'h000000,
   parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
   parameter logic [23:0] KEY_STEP  = 24'h000001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   output logic [23:0] key,
   output logic        key_valid,
   output logic [23:0] key_cur,
   output logic        init_en,
   output logic        ksa_en,
   output logic        prga_en,
   input  logic        init_rdy,
   input  logic        ksa_rdy,
   input  logic        prga_rdy,
   output logic [1:0]  s_sel,
   output logic        ct_sel,
   output logic        pt_sel,
   output logic [7:0]  ct_addr,
   input  logic [7:0]  ct_rddata,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   input  logic        pt_wren_snoop,
   input  logic [7:0]  pt_wrdata_snoop
);

   crack_state_t r_state, w_state_nxt;
   logic [23:0]  r_key_cur, w_key_cur_nxt;
   logic [23:0]  r_key, w_key_nxt;
   logic         r_key_valid, w_key_valid_nxt;
   logic [7:0]   r_len, w_len_nxt;
   logic         r_armed, w_armed_nxt;
   logic [24:0]  w_sum;
`ifdef CRACK_SNOOP_CHECK_EN
   logic         r_bad, w_bad_nxt;
   logic         w_unused;
   assign w_unused = ^{pt_rddata, r_len};
   assign pt_addr  = 8'd0;
`else
   logic [7:0]   r_idx, w_idx_nxt;
   logic         w_unused;
   assign w_unused = ^{pt_wren_snoop, pt_wrdata_snoop};
   assign pt_addr  = pt_sel ? r_idx : 8'd0;
`endif

   assign key       = r_key;
   assign key_valid = r_key_valid;
   assign key_cur   = r_key_cur;
   assign ct_addr   = 8'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_key_cur   <= '0;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_len       <= '0;
         r_armed     <= 1'b0;
`ifdef CRACK_SNOOP_CHECK_EN
         r_bad       <= 1'b0;
`else
         r_idx       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_key_cur   <= w_key_cur_nxt;
         r_key       <= w_key_nxt;
         r_key_valid <= w_key_valid_nxt;
         r_len       <= w_len_nxt;
         r_armed     <= w_armed_nxt;
`ifdef CRACK_SNOOP_CHECK_EN
         r_bad       <= w_bad_nxt;
`else
         r_idx       <= w_idx_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_key_cur_nxt   = r_key_cur;
      w_key_nxt       = r_key;
      w_key_valid_nxt = r_key_valid;
      w_len_nxt       = r_len;
      w_armed_nxt     = r_armed;
      rdy             = 1'b0;
      init_en         = 1'b0;
      ksa_en          = 1'b0;
      prga_en         = 1'b0;
      s_sel           = S_SEL_INIT;
      ct_sel          = 1'b0;
      pt_sel          = 1'b0;
      w_sum           = {1'b0, r_key_cur} + {1'b0, KEY_STEP};
`ifdef CRACK_SNOOP_CHECK_EN
      w_bad_nxt       = r_bad;
`else
      w_idx_nxt       = r_idx;
`endif
      case (r_state)
         ST_IDLE: begin
            rdy = 1'b1;
            if (en) begin
               w_key_cur_nxt   = KEY_FIRST;
               w_key_valid_nxt = 1'b0;
               w_state_nxt     = ST_LEN_REQ;
            end
         end
         ST_LEN_REQ: begin
            ct_sel      = 1'b1;
            w_state_nxt = ST_LEN_GET;
         end
         ST_LEN_GET: begin
            ct_sel      = 1'b1;
            w_len_nxt   = ct_rddata;
            w_state_nxt = ST_INIT_GO;
         end
         // Engine rdy only falls the cycle after its start pulse, so the first WAIT cycle only arms.
         ST_INIT_GO: if (init_rdy) begin
            init_en     = 1'b1;
            w_armed_nxt = 1'b0;
            w_state_nxt = ST_INIT_WAIT;
         end
         ST_INIT_WAIT: begin
            if (!r_armed)     w_armed_nxt = 1'b1;
            else if (init_rdy) w_state_nxt = ST_KSA_GO;
         end
         ST_KSA_GO: begin
            s_sel = S_SEL_KSA;
            if (ksa_rdy) begin
               ksa_en      = 1'b1;
               w_armed_nxt = 1'b0;
               w_state_nxt = ST_KSA_WAIT;
            end
         end
         ST_KSA_WAIT: begin
            s_sel = S_SEL_KSA;
            if (!r_armed)     w_armed_nxt = 1'b1;
            else if (ksa_rdy) w_state_nxt = ST_PRGA_GO;
         end
         ST_PRGA_GO: begin
            s_sel = S_SEL_PRGA;
`ifdef CRACK_SNOOP_CHECK_EN
            w_bad_nxt = 1'b0;
`endif
            if (prga_rdy) begin
               prga_en     = 1'b1;
               w_armed_nxt = 1'b0;
               w_state_nxt = ST_PRGA_WAIT;
            end
         end
         ST_PRGA_WAIT: begin
            s_sel = S_SEL_PRGA;
`ifdef CRACK_SNOOP_CHECK_EN
            w_bad_nxt = r_bad | (pt_wren_snoop & ~is_printable(pt_wrdata_snoop));
`endif
            if (!r_armed) begin
               w_armed_nxt = 1'b1;
            end else if (prga_rdy) begin
`ifdef CRACK_SNOOP_CHECK_EN
               if (w_bad_nxt) begin
                  w_state_nxt = ST_NEXT;
               end else begin
                  w_key_valid_nxt = 1'b1;
                  w_state_nxt     = ST_DONE;
               end
`else
               if (r_len == 8'd0) begin
                  w_key_valid_nxt = 1'b1;
                  w_state_nxt     = ST_DONE;
               end else begin
                  w_idx_nxt   = 8'd0;
                  w_state_nxt = ST_SCAN_REQ;
               end
`endif
            end
         end
`ifndef CRACK_SNOOP_CHECK_EN
         ST_SCAN_REQ: begin
            pt_sel      = 1'b1;
            w_state_nxt = ST_SCAN_GET;
         end
         ST_SCAN_GET: begin
            pt_sel = 1'b1;
            if (!is_printable(pt_rddata)) begin
               w_state_nxt = ST_NEXT;
            end else if (r_idx == r_len - 8'd1) begin
               w_key_valid_nxt = 1'b1;
               w_state_nxt     = ST_DONE;
            end else begin
               w_idx_nxt   = r_idx + 8'd1;
               w_state_nxt = ST_SCAN_REQ;
            end
         end
`endif
         // Sum is one bit wider so a step past 24'hFFFFFF ends the search instead of wrapping.
         ST_NEXT: begin
            if (w_sum > {1'b0, KEY_LAST}) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_key_cur_nxt = w_sum[23:0];
               w_state_nxt   = ST_INIT_GO;
            end
         end
         ST_DONE: begin
            w_key_nxt   = r_key_cur;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule
